// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - Memory-mapped 8N1 UART transmitter with TX FIFO and level IRQ
// Optional parity stage is built when UART_TX_PARITY_EN is defined.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, en, irq_en;
    logic [15:0]   div, div_lat, cnt, div_eff;
    logic [7:0]    sh, sh_next;
    logic [2:0]    bit_idx;
    logic [1:0]    sel, ctrl_hi;
    logic          tx_d, busy, idle, empty, full;
    logic          push_req, push_ok, pop, stat_wr, ctrl_wr, div_wr;
    logic          bit_done, cnt_load;
    logic          unused_bits;
`ifdef UART_TX_PARITY_EN
    logic          par_en, odd, par_en_lat, par_bit;
`endif

    assign unused_bits = &{1'b0, Addr[29:2], Din[31:16]};

    assign sel      = Addr[1:0];
    assign push_req = WE && (sel == 2'd0);
    assign stat_wr  = WE && (sel == 2'd1);
    assign ctrl_wr  = WE && (sel == 2'd2);
    assign div_wr   = WE && (sel == 2'd3);
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign pop      = (state == S_IDLE) && en && !empty;
    // A full FIFO still accepts a byte when the same edge frees a slot.
    assign push_ok  = push_req && (!full || pop);
    assign bit_done = (cnt == 16'd0);
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;
    assign cnt_load = (state_next != state) || ((state == S_DATA) && bit_done);

`ifdef UART_TX_PARITY_EN
    assign ctrl_hi = {odd, par_en};
`else
    assign ctrl_hi = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= Din[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sh_next    = sh;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_START;
                    sh_next    = mem[rd_ptr];
                end
            end
            S_START: if (bit_done) state_next = S_DATA;
            S_DATA: begin
                if (bit_done) begin
                    sh_next = {1'b0, sh[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = par_en_lat ? S_PARITY : S_STOP;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_done) state_next = S_STOP;
`endif
            S_STOP: if (bit_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the start bit leaves on the pop edge.
    always_comb begin
        busy = (state != S_IDLE);
        idle = empty && !busy;
        tx_d = 1'b1;
        case (state_next)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_bit;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            div      <= DIV_RESET;
            div_lat  <= DIV_RESET;
            cnt      <= 16'd0;
            sh       <= 8'd0;
            bit_idx  <= 3'd0;
            tx       <= 1'b1;
            IRQ      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en     <= 1'b0;
            odd        <= 1'b0;
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else begin
            sh  <= sh_next;
            tx  <= tx_d;
            IRQ <= irq_en && idle;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (stat_wr)         overflow <= 1'b0;
            if (ctrl_wr) begin
                en     <= Din[0];
                irq_en <= Din[1];
`ifdef UART_TX_PARITY_EN
                par_en <= Din[2];
                odd    <= Din[3];
`endif
            end
            if (div_wr) div <= Din[15:0];
            // Divisor and frame options are frozen for the whole frame at pop time.
            if (pop) begin
                div_lat <= div_eff;
                bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                par_en_lat <= par_en;
                par_bit    <= (^mem[rd_ptr]) ^ odd;
`endif
            end else if ((state == S_DATA) && bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (cnt_load)      cnt <= (pop ? div_eff : div_lat) - 16'd1;
            else if (!bit_done) cnt <= cnt - 16'd1;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            2'd1:    Dout = {16'd0, 8'(count), 3'd0, overflow, idle, empty, full, busy};
            2'd2:    Dout = {28'd0, ctrl_hi, irq_en, en};
            2'd3:    Dout = {16'd0, div};
            default: Dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - Directed self-checking bench for uart_tx_dev
module tb_uart_tx_dev;
    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [127:0] exp_v, got_v;
    int           exp_len;
    logic [31:0]  rdata;

    localparam logic [1:0] A_TX = 2'd0, A_ST = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

    uart_tx_dev dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .IRQ(IRQ), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE  = 1'b0;
        Din = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a};
        #1;
        d = Dout;
    endtask

    task automatic cap_tx(input int n);
        got_v = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            got_v[i] = tx;
        end
    endtask

    task automatic clear_exp();
        exp_v   = '0;
        exp_len = 0;
    endtask

    task automatic add_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_v[exp_len] = b;
            exp_len++;
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input int div);
        add_bits(1'b0, div);
        for (int i = 0; i < 8; i++) add_bits(d[i], div);
        add_bits(1'b1, div);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 30'd0;
        Din   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rd(A_TX, rdata);
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL reset_txdata: got %h expected %h", rdata, 32'd0);
        else pass_cnt++;
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_000C) $display("FAIL reset_status: got %h expected %h", rdata, 32'h0000_000C);
        else pass_cnt++;
        rd(A_CTRL, rdata);
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL reset_ctrl: got %h expected %h", rdata, 32'd0);
        else pass_cnt++;
        rd(A_DIV, rdata);
        total_cnt++;
        if (rdata !== 32'd434) $display("FAIL reset_div: got %0d expected %0d", rdata, 434);
        else pass_cnt++;
        total_cnt++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
        else pass_cnt++;
        total_cnt++;
        if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ);
        else pass_cnt++;
    endtask

    task automatic test_single_byte();
        do_reset();
        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'd1);
        wr(A_TX, 32'h0000_00A5);
        total_cnt++;
        if (tx !== 1'b1) $display("FAIL single_pre_start: got %b expected 1", tx);
        else pass_cnt++;
        clear_exp();
        add_frame(8'hA5, 4);
        cap_tx(exp_len);
        total_cnt++;
        if (got_v !== exp_v) $display("FAIL single_frame: got %h expected %h", got_v, exp_v);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_000C) $display("FAIL single_status_after: got %h expected %h", rdata, 32'h0000_000C);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'd1);
        wr(A_TX, 32'h0000_003C);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (tx !== 1'b0) $display("FAIL midreset_start_bit: got %b expected 0", tx);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (tx !== 1'b1) $display("FAIL midreset_tx: got %b expected 1", tx);
        else pass_cnt++;
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_000C) $display("FAIL midreset_status: got %h expected %h", rdata, 32'h0000_000C);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        wr(A_DIV, 32'd1);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + 32'(i));
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_0812) $display("FAIL fifo_full_status: got %h expected %h", rdata, 32'h0000_0812);
        else pass_cnt++;
        wr(A_ST, 32'd0);
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_0802) $display("FAIL fifo_ovf_clear: got %h expected %h", rdata, 32'h0000_0802);
        else pass_cnt++;
        wr(A_CTRL, 32'd1);
        clear_exp();
        for (int k = 0; k < 8; k++) begin
            add_frame(8'h10 + 8'(k), 1);
            add_bits(1'b1, 1);
        end
        cap_tx(exp_len);
        total_cnt++;
        if (got_v !== exp_v) $display("FAIL fifo_drain_frames: got %h expected %h", got_v, exp_v);
        else pass_cnt++;
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_000C) $display("FAIL fifo_drained_status: got %h expected %h", rdata, 32'h0000_000C);
        else pass_cnt++;
    endtask

    task automatic test_push_on_pop();
        do_reset();
        wr(A_DIV, 32'd1);
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h20 + 32'(i));
        wr(A_CTRL, 32'd1);
        wr(A_TX, 32'h0000_0055);
        rd(A_ST, rdata);
        total_cnt++;
        if (rdata !== 32'h0000_0803) $display("FAIL push_on_pop_status: got %h expected %h", rdata, 32'h0000_0803);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        do_reset();
        wr(A_DIV, 32'd1);
        wr(A_CTRL, 32'd3);
        wr(A_TX, 32'd0);
        total_cnt++;
        if (IRQ !== 1'b1) $display("FAIL irq_idle_before: got %b expected 1", IRQ);
        else pass_cnt++;
        got_v = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            got_v[i] = IRQ;
        end
        total_cnt++;
        if (got_v !== 128'h800) $display("FAIL irq_frame_trace: got %h expected %h", got_v, 128'h800);
        else pass_cnt++;
        wr(A_CTRL, 32'd1);
        total_cnt++;
        if (IRQ !== 1'b1) $display("FAIL irq_clear_lag: got %b expected 1", IRQ);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (IRQ !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", IRQ);
        else pass_cnt++;
    endtask

    task automatic test_div_zero_parity();
        do_reset();
        wr(A_DIV, 32'd0);
`ifdef UART_TX_PARITY_EN
        wr(A_CTRL, 32'd5);
        rd(A_CTRL, rdata);
        total_cnt++;
        if (rdata !== 32'd5) $display("FAIL par_ctrl_read: got %h expected %h", rdata, 32'd5);
        else pass_cnt++;
        wr(A_TX, 32'h07);
        clear_exp();
        add_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) add_bits(i < 3, 1);
        add_bits(1'b1, 1);
        add_bits(1'b1, 1);
        add_bits(1'b1, 1);
        cap_tx(exp_len);
        total_cnt++;
        if (got_v !== exp_v) $display("FAIL par_even_frame: got %h expected %h", got_v, exp_v);
        else pass_cnt++;
        wr(A_CTRL, 32'hD);
        wr(A_TX, 32'h07);
        clear_exp();
        add_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) add_bits(i < 3, 1);
        add_bits(1'b0, 1);
        add_bits(1'b1, 1);
        add_bits(1'b1, 1);
        cap_tx(exp_len);
        total_cnt++;
        if (got_v !== exp_v) $display("FAIL par_odd_frame: got %h expected %h", got_v, exp_v);
        else pass_cnt++;
`else
        wr(A_CTRL, 32'hF);
        rd(A_CTRL, rdata);
        total_cnt++;
        if (rdata !== 32'd3) $display("FAIL ctrl_par_bits_masked: got %h expected %h", rdata, 32'd3);
        else pass_cnt++;
        wr(A_TX, 32'h07);
        clear_exp();
        add_frame(8'h07, 1);
        add_bits(1'b1, 1);
        cap_tx(exp_len);
        total_cnt++;
        if (got_v !== exp_v) $display("FAIL div_zero_frame: got %h expected %h", got_v, exp_v);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_reset_mid_frame();
        test_fifo_overflow();
        test_push_on_pop();
        test_irq();
        test_div_zero_parity();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
